icache: RTL and testbench

- Direct-mapped, one-word-per-line instruction cache between the decoder's fetch port and the memory controller's instruction port.
- On a hit, it serves the decoder's fetch request from internal storage with 1-cycle latency.
- On a miss, it forwards the fetch to memctrl, fills the line, and returns the word.
- `clear` (branch mispredict flush) aborts an in-flight response without corrupting the cache.

---
 rtl/icache.sv | 138 +++++++++++++
 tb/tb_icache.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/icache.sv
// Direct-mapped, one-word-per-line instruction cache between the decoder fetch port
// and the memory controller instruction port.
module icache #(
  parameter int unsigned INDEX_WIDTH = 6
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        clear,
  input  logic        if_enable,
  input  logic [31:0] if_addr,
  output logic        inst_ready,
  output logic [31:0] inst,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ready,
  input  logic [31:0] mem_inst
);

  localparam int unsigned Lines = 1 << INDEX_WIDTH;
  localparam int unsigned TagW  = 30 - INDEX_WIDTH;

  typedef logic [INDEX_WIDTH-1:0] idx_t;
  typedef logic [TagW-1:0]        tag_t;

  typedef enum logic [0:0] {StIdle, StMiss} state_e;

  state_e      state_q, state_d;
  logic        inst_ready_q, inst_ready_d;
  logic [31:0] inst_q, inst_d;
  logic        mem_req_q, mem_req_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  idx_t        miss_idx_q, miss_idx_d;
  tag_t        miss_tag_q, miss_tag_d;
  logic        fill_en;

  logic [Lines-1:0] valid_q;
  tag_t             tag_mem  [Lines];
  logic [31:0]      data_mem [Lines];

  idx_t req_idx;
  tag_t req_tag;
  logic hit;
  logic unused_addr_bits;

  assign req_idx          = if_addr[INDEX_WIDTH+1:2];
  assign req_tag          = if_addr[31:INDEX_WIDTH+2];
  assign hit              = valid_q[req_idx] && (tag_mem[req_idx] == req_tag);
  assign unused_addr_bits = ^if_addr[1:0];

  always_comb begin
    state_d      = state_q;
    inst_ready_d = 1'b0;
    inst_d       = inst_q;
    mem_req_d    = mem_req_q;
    mem_addr_d   = mem_addr_q;
    miss_idx_d   = miss_idx_q;
    miss_tag_d   = miss_tag_q;
    fill_en      = 1'b0;

    if (!rdy_in) begin
      inst_ready_d = inst_ready_q;
    end else if (clear) begin
      state_d   = StIdle;
      mem_req_d = 1'b0;
      // A response landing with the flush is still good data; keep it, just don't deliver it.
      if (state_q == StMiss && mem_ready) begin
        fill_en = 1'b1;
      end
    end else begin
      unique case (state_q)
        StIdle: begin
          // inst_ready_q guard stops a held if_enable from re-accepting the same fetch.
          if (if_enable && !inst_ready_q) begin
            if (hit) begin
              inst_ready_d = 1'b1;
              inst_d       = data_mem[req_idx];
            end else begin
              mem_req_d  = 1'b1;
              mem_addr_d = {if_addr[31:2], 2'b00};
              miss_idx_d = req_idx;
              miss_tag_d = req_tag;
              state_d    = StMiss;
            end
          end
        end
        StMiss: begin
          if (mem_ready) begin
            fill_en      = 1'b1;
            inst_d       = mem_inst;
            inst_ready_d = 1'b1;
            mem_req_d    = 1'b0;
            state_d      = StIdle;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q      <= StIdle;
      inst_ready_q <= 1'b0;
      inst_q       <= '0;
      mem_req_q    <= 1'b0;
      mem_addr_q   <= '0;
      miss_idx_q   <= '0;
      miss_tag_q   <= '0;
      valid_q      <= '0;
    end else begin
      state_q      <= state_d;
      inst_ready_q <= inst_ready_d;
      inst_q       <= inst_d;
      mem_req_q    <= mem_req_d;
      mem_addr_q   <= mem_addr_d;
      miss_idx_q   <= miss_idx_d;
      miss_tag_q   <= miss_tag_d;
      if (fill_en) begin
        valid_q[miss_idx_q] <= 1'b1;
      end
    end
  end

  // Tag/data arrays carry no reset; valid_q alone qualifies them.
  always_ff @(posedge clk_in) begin
    if (fill_en) begin
      tag_mem[miss_idx_q]  <= miss_tag_q;
      data_mem[miss_idx_q] <= mem_inst;
    end
  end

  assign inst_ready = inst_ready_q;
  assign inst       = inst_q;
  assign mem_req    = mem_req_q;
  assign mem_addr   = mem_addr_q;

endmodule

// File: tb/tb_icache.sv
// Self-checking bench for icache: directed scenarios plus random fetches checked
// against a line-address reference model and a synthetic instruction memory.
module tb_icache;

  localparam int IW = 6;
  localparam int NumLines = 1 << IW;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rdy = 1'b1;
  logic        clear = 1'b0;
  logic        if_enable = 1'b0;
  logic [31:0] if_addr = '0;
  logic        mem_ready = 1'b0;
  logic [31:0] mem_inst = '0;
  logic        inst_ready;
  logic [31:0] inst;
  logic        mem_req;
  logic [31:0] mem_addr;

  int n_tests = 0;
  int n_fail = 0;

  // Model: which word address each line currently holds.
  bit          ref_v [NumLines];
  logic [31:0] ref_a [NumLines];

  icache #(.INDEX_WIDTH(IW)) dut (
    .clk_in    (clk),
    .rst_in    (rst_n),
    .rdy_in    (rdy),
    .clear     (clear),
    .if_enable (if_enable),
    .if_addr   (if_addr),
    .inst_ready(inst_ready),
    .inst      (inst),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .mem_ready (mem_ready),
    .mem_inst  (mem_inst)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mem_img(input logic [31:0] a);
    logic [31:0] w;
    w = {a[31:2], 2'b00};
    case (w)
      32'h0000_0000: return 32'h0000_0013;
      32'h0000_0100: return 32'h0010_0093;
      32'h0000_0080: return 32'hDEAD_BEEF;
      default:       return (w * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endcase
  endfunction

  function automatic bit ref_hit(input logic [31:0] a);
    int idx;
    idx = int'(a[IW+1:2]);
    return ref_v[idx] && (ref_a[idx] == {a[31:2], 2'b00});
  endfunction

  // One fetch; on a miss memctrl answers after 'delay' wait cycles.
  task automatic fetch(input logic [31:0] a, input int delay);
    logic [31:0] w;
    bit          exp_hit;
    int          idx;
    w       = {a[31:2], 2'b00};
    exp_hit = ref_hit(a);
    idx     = int'(a[IW+1:2]);
    if_enable = 1'b1;
    if_addr   = a;
    step();
    if_enable = 1'b0;
    if (exp_hit) begin
      check("hit_ready", 32'(inst_ready), 32'd1);
      check("hit_inst", inst, mem_img(a));
      check("hit_no_req", 32'(mem_req), 32'd0);
    end else begin
      check("miss_req", 32'(mem_req), 32'd1);
      check("miss_addr", mem_addr, w);
      check("miss_no_ready", 32'(inst_ready), 32'd0);
      repeat (delay) begin
        step();
        check("miss_hold_req", 32'(mem_req), 32'd1);
        check("miss_hold_addr", mem_addr, w);
      end
      mem_ready = 1'b1;
      mem_inst  = mem_img(a);
      step();
      mem_ready = 1'b0;
      check("fill_ready", 32'(inst_ready), 32'd1);
      check("fill_inst", inst, mem_img(a));
      check("fill_req_drop", 32'(mem_req), 32'd0);
      ref_v[idx] = 1'b1;
      ref_a[idx] = w;
    end
    step();
    check("pulse_end", 32'(inst_ready), 32'd0);
  endtask

  initial begin
    logic [31:0] a;

    // Reset
    repeat (2) step();
    check("rst_inst_ready", 32'(inst_ready), 32'd0);
    check("rst_inst", inst, 32'd0);
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    rst_n = 1'b1;
    step();

    // Cold miss, hit, conflict
    fetch(32'h0000_0000, 3);
    fetch(32'h0000_0000, 0);
    fetch(32'h0000_0100, 1);
    fetch(32'h0000_0000, 2);

    // Held if_enable: accept, pulse, accept, pulse
    if_enable = 1'b1;
    if_addr   = 32'h0000_0000;
    step();
    check("b2b_first", 32'(inst_ready), 32'd1);
    step();
    check("b2b_gap", 32'(inst_ready), 32'd0);
    check("b2b_gap_req", 32'(mem_req), 32'd0);
    step();
    check("b2b_second", 32'(inst_ready), 32'd1);
    if_enable = 1'b0;
    step();
    check("b2b_end", 32'(inst_ready), 32'd0);

    // Clear drops a same-cycle hit request
    if_enable = 1'b1;
    clear     = 1'b1;
    step();
    if_enable = 1'b0;
    clear     = 1'b0;
    check("clr_idle_ready", 32'(inst_ready), 32'd0);
    check("clr_idle_req", 32'(mem_req), 32'd0);

    // Clear mid-miss on 0x40, then a stray mem_ready in IDLE
    if_enable = 1'b1;
    if_addr   = 32'h0000_0040;
    step();
    if_enable = 1'b0;
    check("clrmiss_req", 32'(mem_req), 32'd1);
    step();
    clear = 1'b1;
    step();
    clear = 1'b0;
    check("clrmiss_req_drop", 32'(mem_req), 32'd0);
    check("clrmiss_no_ready", 32'(inst_ready), 32'd0);
    mem_ready = 1'b1;
    mem_inst  = 32'hBAD0_BAD0;
    step();
    mem_ready = 1'b0;
    check("stray_no_ready", 32'(inst_ready), 32'd0);
    check("stray_no_req", 32'(mem_req), 32'd0);
    step();
    fetch(32'h0000_0040, 1);

    // Clear coincident with mem_ready for 0x80: filled but not delivered
    if_enable = 1'b1;
    if_addr   = 32'h0000_0080;
    step();
    if_enable = 1'b0;
    check("clrfill_req", 32'(mem_req), 32'd1);
    step();
    clear     = 1'b1;
    mem_ready = 1'b1;
    mem_inst  = 32'hDEAD_BEEF;
    step();
    clear     = 1'b0;
    mem_ready = 1'b0;
    check("clrfill_no_ready", 32'(inst_ready), 32'd0);
    check("clrfill_req_drop", 32'(mem_req), 32'd0);
    ref_v[32] = 1'b1;
    ref_a[32] = 32'h0000_0080;
    step();
    fetch(32'h0000_0080, 0);

    // rdy_in stall in MISS with a response arriving during the stall
    if_enable = 1'b1;
    if_addr   = 32'h0000_0300;
    step();
    if_enable = 1'b0;
    check("stall_req", 32'(mem_req), 32'd1);
    rdy = 1'b0;
    for (int i = 0; i < 4; i++) begin
      mem_ready = (i == 1);
      mem_inst  = mem_img(32'h0000_0300);
      step();
      check("stall_hold_req", 32'(mem_req), 32'd1);
      check("stall_hold_addr", mem_addr, 32'h0000_0300);
      check("stall_no_ready", 32'(inst_ready), 32'd0);
    end
    mem_ready = 1'b0;
    rdy       = 1'b1;
    step();
    check("stall_still_miss", 32'(mem_req), 32'd1);
    check("stall_still_noready", 32'(inst_ready), 32'd0);
    mem_ready = 1'b1;
    step();
    mem_ready = 1'b0;
    check("stall_done_ready", 32'(inst_ready), 32'd1);
    check("stall_done_inst", inst, mem_img(32'h0000_0300));
    ref_v[0] = 1'b1;
    ref_a[0] = 32'h0000_0300;
    step();
    check("stall_pulse_end", 32'(inst_ready), 32'd0);

    // Random fetches over a small tag pool to mix hits, misses and conflicts
    for (int n = 0; n < 300; n++) begin
      a = ($urandom_range(0, 3) << (IW + 2)) | ($urandom_range(0, NumLines - 1) << 2)
          | $urandom_range(0, 3);
      fetch(a, int'($urandom_range(0, 3)));
    end

    // Asynchronous reset mid-run invalidates everything
    rst_n = 1'b0;
    #2;
    check("arst_inst_ready", 32'(inst_ready), 32'd0);
    check("arst_inst", inst, 32'd0);
    check("arst_mem_req", 32'(mem_req), 32'd0);
    check("arst_mem_addr", mem_addr, 32'd0);
    for (int i = 0; i < NumLines; i++) ref_v[i] = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    fetch(32'h0000_0000, 1);
    fetch(32'h0000_0000, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
